// File: rtl/nx_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nx_stream_arbiter
// Brief    : Round-robin burst arbiter merging PORTS streams into a 2-deep FIFO.
// Revision : 1.0
// ============================================================================
module nx_stream_arbiter #(
  parameter int STREAM_WIDTH = 32,
  parameter int PORTS        = 4,
  parameter int BURST_MAX    = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [PORTS*STREAM_WIDTH-1:0]   in_data_i,
  input  logic [2*PORTS-1:0]              in_dir_i,
  input  logic [PORTS-1:0]                in_valid_i,
  output logic [PORTS-1:0]                in_ready_o,
  output logic [STREAM_WIDTH-1:0]         out_data_o,
  output logic [1:0]                      out_dir_o,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [PORTS-1:0]                grant_o,
  output logic                            idle_o
);

  localparam int         c_idxw     = $clog2(PORTS);
  localparam int         c_ew       = STREAM_WIDTH + 2;
  localparam logic [0:0] c_st_idle  = 1'b0;
  localparam logic [0:0] c_st_grant = 1'b1;

  logic [0:0]          r_state, w_state_nx;
  logic [PORTS-1:0]    r_grant, w_grant_nx;
  logic [c_idxw-1:0]   r_ptr, w_ptr_nx;
  logic [3:0]          r_cnt, w_cnt_nx;
  logic [c_ew-1:0]     r_mem [2];
  logic                r_wr, r_rd;
  logic [1:0]          r_count;

  logic                w_found;
  logic [c_idxw-1:0]   w_sel;
  logic [c_idxw:0]     w_sum;
  logic [STREAM_WIDTH-1:0] w_in_data;
  logic [1:0]          w_in_dir;
  logic                w_gvalid, w_full, w_push, w_pop, w_release;

  // Round-robin search starting just after the most recently granted port.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_ptr;
    w_sum   = '0;
    for (int k = 1; k <= PORTS; k++) begin
      w_sum = {1'b0, r_ptr} + (c_idxw+1)'(k);
      if (w_sum >= (c_idxw+1)'(PORTS))
        w_sum = w_sum - (c_idxw+1)'(PORTS);
      if (!w_found && in_valid_i[w_sum[c_idxw-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_sum[c_idxw-1:0];
      end
    end
  end

  always_comb begin
    w_in_data = '0;
    w_in_dir  = '0;
    w_gvalid  = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      if (r_ptr == c_idxw'(p)) begin
        w_in_data = in_data_i[p*STREAM_WIDTH +: STREAM_WIDTH];
        w_in_dir  = in_dir_i[p*2 +: 2];
        w_gvalid  = in_valid_i[p];
      end
    end
  end

  assign w_full    = (r_count == 2'd2);
  assign w_push    = (r_state == c_st_grant) && w_gvalid && !w_full;
  assign w_pop     = (r_count != 2'd0) && out_ready_i;
  assign w_release = !w_gvalid || (w_push && (r_cnt == 4'(BURST_MAX-1)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= c_st_idle;
      r_grant <= '0;
      r_ptr   <= c_idxw'(PORTS-1);
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nx;
      r_grant <= w_grant_nx;
      r_ptr   <= w_ptr_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_ptr_nx   = r_ptr;
    w_cnt_nx   = r_cnt;
    case (r_state)
      c_st_idle: begin
        if (w_found) begin
          w_state_nx = c_st_grant;
          w_grant_nx = {{(PORTS-1){1'b0}}, 1'b1} << w_sel;
          w_ptr_nx   = w_sel;
          w_cnt_nx   = 4'd0;
        end
      end
      default: begin
        if (w_push)
          w_cnt_nx = r_cnt + 4'd1;
        // Stalled beats leave the counter alone, so backpressure never ends a burst.
        if (w_release) begin
          w_cnt_nx = 4'd0;
          if (w_found) begin
            w_grant_nx = {{(PORTS-1){1'b0}}, 1'b1} << w_sel;
            w_ptr_nx   = w_sel;
          end else begin
            w_state_nx = c_st_idle;
            w_grant_nx = '0;
          end
        end
      end
    endcase
  end

  always_comb begin
    grant_o     = r_grant;
    in_ready_o  = r_grant & {PORTS{~w_full}};
    idle_o      = (r_state == c_st_idle) && (r_count == 2'd0);
    out_valid_o = (r_count != 2'd0);
    {out_data_o, out_dir_o} = out_valid_o ? r_mem[r_rd] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wr <= ~r_wr;
      if (w_pop)  r_rd <= ~r_rd;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push)
      r_mem[r_wr] <= {w_in_data, w_in_dir};
  end

endmodule
`default_nettype wire

// File: tb/tb_nx_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_nx_stream_arbiter
// Brief    : Vector table, directed sequences and random traffic vs. a queue model.
// Revision : 1.0
// ============================================================================
module tb_nx_stream_arbiter;
  localparam int W = 32;
  localparam int P = 4;
  localparam int B = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [P*W-1:0]   in_data;
  logic [2*P-1:0]   in_dir;
  logic [P-1:0]     in_valid, in_ready, grant;
  logic [W-1:0]     out_data;
  logic [1:0]       out_dir;
  logic             out_valid, out_ready, idle;

  always #5 clk = ~clk;

  nx_stream_arbiter #(.STREAM_WIDTH(W), .PORTS(P), .BURST_MAX(B)) dut (
    .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_dir_i(in_dir),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .out_data_o(out_data),
    .out_dir_o(out_dir), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .grant_o(grant), .idle_o(idle)
  );

  typedef struct {
    logic         rst;
    logic [P-1:0] v;
    logic         ordy;
    logic [P-1:0] eg;
    logic [P-1:0] erdy;
    logic         eov;
    logic [W+1:0] eout;
    logic         eidle;
  } vec_t;

  vec_t         tbl [11];
  int           n_vec = 0;
  int           n_err = 0;
  int           m_g, m_last, m_beats, n_solo;
  logic [W+1:0] m_q [$];
  logic [P-1:0] seen [$];
  logic [P-1:0] lastg, rv;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Reference: grant index (-1 idle), last granted port, beats in burst, FIFO as a queue.
  task automatic model_reset();
    m_g = -1; m_last = P-1; m_beats = 0; m_q.delete();
  endtask

  function automatic int search(input int base);
    for (int k = 1; k <= P; k++) begin
      int i = (base + k) % P;
      if (in_valid[i[1:0]]) return i;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int   n;
    logic acc;
    if (rst) begin model_reset(); return; end
    acc = (m_g >= 0) && in_valid[m_g[1:0]] && (m_q.size() < 2);
    if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
    if (acc) m_q.push_back({in_data[m_g*W +: W], in_dir[m_g*2 +: 2]});
    if (m_g < 0) begin
      n = search(m_last);
      if (n >= 0) begin m_g = n; m_last = n; m_beats = 0; end
    end else begin
      if (acc) m_beats++;
      if (!in_valid[m_g[1:0]] || m_beats == B) begin
        n = search(m_g);
        m_g = n;
        if (n >= 0) m_last = n;
        m_beats = 0;
      end
    end
  endtask

  task automatic check_outs();
    logic [P-1:0] eg;
    logic [W+1:0] eo;
    eg = '0;
    if (m_g >= 0) eg[m_g[1:0]] = 1'b1;
    eo = (m_q.size() > 0) ? m_q[0] : '0;
    chk("grant", 64'(grant), 64'(eg));
    chk("in_ready", 64'(in_ready), 64'((m_q.size() < 2) ? eg : '0));
    chk("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
    chk("out_payload", 64'({out_data, out_dir}), 64'(eo));
    chk("idle", 64'(idle), 64'((m_g < 0) && (m_q.size() == 0)));
  endtask

  task automatic cyc(input logic r, input logic [P-1:0] v, input logic ordy,
                     input bit rnd, input bit do_chk);
    rst = r; in_valid = v; out_ready = ordy;
    if (rnd) begin
      for (int p = 0; p < P; p++) begin
        in_data[p*W +: W] = $urandom;
        in_dir[p*2 +: 2]  = 2'($urandom_range(0, 3));
      end
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (do_chk) check_outs();
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; out_ready = 1'b1;
    in_data = {32'h13, 32'hA5, 32'h11, 32'h10};
    in_dir  = {2'd3, 2'd1, 2'd1, 2'd0};
    model_reset();

    //           rst   valid    ordy  grant    ready    ov    payload          idle
    tbl[0]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 34'h0,           1'b1};
    tbl[1]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b0, 34'h0,           1'b0};
    tbl[2]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1, {32'hA5, 2'd1}, 1'b0};
    tbl[3]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 34'h0,           1'b1};
    tbl[4]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 34'h0,           1'b1};
    tbl[5]  = '{1'b0, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b0, 34'h0,           1'b0};
    tbl[6]  = '{1'b0, 4'b1010, 1'b1, 4'b0010, 4'b0010, 1'b1, {32'h11, 2'd1}, 1'b0};
    tbl[7]  = '{1'b0, 4'b1010, 1'b1, 4'b0010, 4'b0010, 1'b1, {32'h11, 2'd1}, 1'b0};
    tbl[8]  = '{1'b0, 4'b1000, 1'b1, 4'b1000, 4'b1000, 1'b0, 34'h0,           1'b0};
    tbl[9]  = '{1'b0, 4'b1000, 1'b1, 4'b1000, 4'b1000, 1'b1, {32'h13, 2'd3}, 1'b0};
    tbl[10] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 34'h0,           1'b1};

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].rst, tbl[i].v, tbl[i].ordy, 1'b0, 1'b0);
      chk($sformatf("row%0d_grant", i), 64'(grant), 64'(tbl[i].eg));
      chk($sformatf("row%0d_ready", i), 64'(in_ready), 64'(tbl[i].erdy));
      chk($sformatf("row%0d_ovalid", i), 64'(out_valid), 64'(tbl[i].eov));
      chk($sformatf("row%0d_payload", i), 64'({out_data, out_dir}), 64'(tbl[i].eout));
      chk($sformatf("row%0d_idle", i), 64'(idle), 64'(tbl[i].eidle));
    end

    // All four ports requesting: round-robin order 0,1,2,3,0.
    cyc(1'b1, 4'h0, 1'b1, 1'b1, 1'b1);
    lastg = '0;
    repeat (20) begin
      cyc(1'b0, 4'hF, 1'b1, 1'b1, 1'b1);
      if (grant != 4'h0 && grant != lastg) seen.push_back(grant);
      lastg = grant;
    end
    for (int k = 0; k < 5; k++)
      chk($sformatf("rr_order%0d", k), 64'((seen.size() > k) ? seen[k] : 4'h0),
          64'(4'h1 << (k % 4)));

    // Backpressure: FIFO fills after two beats, then a lone requester is re-granted.
    cyc(1'b1, 4'h0, 1'b1, 1'b1, 1'b1);
    repeat (5) cyc(1'b0, 4'h1, 1'b0, 1'b1, 1'b1);
    chk("bp_ready_low", 64'(in_ready), 64'(0));
    chk("bp_out_valid", 64'(out_valid), 64'(1));
    n_solo = 0;
    repeat (12) begin
      cyc(1'b0, 4'h1, 1'b1, 1'b1, 1'b1);
      if (grant == 4'h1) n_solo++;
    end
    chk("solo_regrant", 64'(n_solo), 64'(12));

    // Reset with two beats buffered under a grant to port 2.
    cyc(1'b1, 4'h0, 1'b1, 1'b1, 1'b1);
    repeat (3) cyc(1'b0, 4'h4, 1'b0, 1'b1, 1'b1);
    chk("pre_rst_full", 64'(out_valid), 64'(1));
    cyc(1'b1, 4'h4, 1'b1, 1'b1, 1'b1);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_grant", 64'(grant), 64'(0));
    repeat (3) begin
      cyc(1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
      chk("no_stale_beat", 64'(out_valid), 64'(0));
    end

    // Random traffic against the reference model.
    rv = '0;
    repeat (600) begin
      if ($urandom_range(0, 3) == 0) rv = 4'($urandom);
      cyc(1'($urandom_range(0, 149) == 0), rv, 1'($urandom_range(0, 3) != 0), 1'b1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nx_stream_arbiter.md
NX_STREAM_ARBITER -- requirements
Module: nx_stream_arbiter

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- STREAM_WIDTH, 32, payload width.
- PORTS, 4, number of inbound streams (2..8).
- BURST_MAX, 4, maximum consecutive beats per grant (1..15).
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk_i, in, 1, clock.
- rst_i, in, 1, reset.
- in_data_i, in, PORTS x STREAM_WIDTH, inbound payloads.
- in_dir_i, in, PORTS x 2, inbound directions.
- in_valid_i, in, PORTS, inbound valid.
- in_ready_o, out, PORTS, inbound ready.
- out_data_o, out, STREAM_WIDTH, arbitrated payload.
- out_dir_o, out, 2, arbitrated direction.
- out_valid_o, out, 1, output valid.
- out_ready_i, in, 1, output ready.
- grant_o, out, PORTS, one-hot current grant (zero when idle).
- idle_o, out, 1, high when in IDLE and the buffer is empty.
REQ-003 The block SHALL use one clock, clk_i; rst_i SHALL be synchronous and active-high.

Function
REQ-004 Inbound transfer on port p SHALL occur when in_valid_i[p] and in_ready_o[p] are both high at a clk_i rising edge; outbound transfer SHALL occur when out_valid_o and out_ready_i are both high.
REQ-005 in_ready_o[p] SHALL equal grant_o[p] AND NOT buffer-full, derived only from registered state (no combinational path from in_valid_i or out_ready_i).
REQ-006 The FSM SHALL have two states, IDLE and GRANT.
REQ-007 IDLE to GRANT: when any in_valid_i is high, the block SHALL register the grant to the first valid port searching upward from (ptr+1) mod PORTS, wrapping; grant_o SHALL be visible the following cycle.
REQ-008 ptr SHALL hold the index of the most recently granted port.
REQ-009 In GRANT, each accepted beat SHALL increment a burst counter.
REQ-010 A grant SHALL be released at the edge where the BURST_MAX-th beat is accepted, or where the granted port's in_valid_i is low.
REQ-011 On release, the next grant SHALL be selected in the same cycle by the REQ-007 search from (released+1) mod PORTS over the current in_valid_i, re-granting the released port only if it is the sole requester.
- The burst counter SHALL clear on each new grant.
- If no port is valid, the FSM SHALL enter IDLE.
REQ-012 Accepted beats SHALL enter a 2-entry FIFO holding {data, dir}; out_* SHALL present the FIFO head.
- Latency from inbound accept to out_valid_o SHALL be one cycle.
- Sustained throughput SHALL be one beat per cycle.
REQ-013 With the FIFO full, no inbound beat SHALL be accepted; a simultaneous pop and push on a full FIFO SHALL NOT occur, because ready is registered low.
REQ-014 Beat order SHALL be preserved; no beat SHALL be dropped or duplicated.
REQ-015 A beat stalled by backpressure SHALL NOT count toward BURST_MAX; the grant SHALL hold while in_valid_i stays high.
REQ-016 The burst counter SHALL be 4 bits and SHALL NOT wrap beyond BURST_MAX.

Reset
REQ-017 While rst_i is high at an edge, the block SHALL set: state IDLE, ptr PORTS-1, burst counter 0, FIFO empty.
- Resulting outputs: grant_o 0, in_ready_o 0, out_valid_o 0, idle_o 1.
- out_data_o and out_dir_o SHALL be 0.
REQ-018 Reset asserted mid-burst SHALL discard buffered beats and the grant.
- The first grant after reset SHALL go to port 0 if port 0 is valid.

Verification
REQ-019 The bench SHALL cover the following directed scenarios (PORTS=4, BURST_MAX=4):
- Reset, then port 2 valid with 0xA5 dir 1 -> grant_o=0100 next cycle; out 0xA5/dir 1 one cycle after accept; idle_o=1 after drain.
- Ports 0..3 continuously valid, out_ready_i=1 -> grants 0,1,2,3,0 in turn, exactly 4 beats each, 16 beats in order.
- Port 1 sends 2 beats then drops valid while port 3 is valid -> release after 2 beats; grant_o=1000 next cycle.
- out_ready_i=0 with port 0 streaming -> exactly 2 beats accepted, then in_ready_o=0; burst counter=2; after ready returns, remaining beats flow with no loss.
- Only port 0 valid continuously -> re-granted to port 0 after each 4-beat burst; no gap beyond the release cycle.
- rst_i pulsed with FIFO holding 2 beats during a grant to port 2 -> out_valid_o=0 and grant_o=0 next cycle; buffered beats never appear.
